// File: rtl/fetch_queue_if.sv
// Bundle for fetch_queue: instruction-memory request/response bus, resolved branch info
// and the valid/ready instruction handshake toward decode.
interface fetch_queue_if #(
    parameter int WIDTH = 32
) ();
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_gnt;
    logic             imem_valid;
    logic [WIDTH-1:0] imem_rdata;

    logic             br_valid;
    logic [WIDTH-1:0] br_pc;
    logic [25:0]      br_imm26;
    logic             br_beq;
    logic             br_bne;
    logic             br_j;
    logic             br_zf;

    logic             inst_valid;
    logic             inst_ready;
    logic [WIDTH-1:0] inst_data;
    logic [WIDTH-1:0] inst_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_valid, imem_rdata,
        input  br_valid, br_pc, br_imm26, br_beq, br_bne, br_j, br_zf,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_valid, imem_rdata,
        output br_valid, br_pc, br_imm26, br_beq, br_bne, br_j, br_zf,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner, single-outstanding imem requester and DEPTH-entry PC-tagged queue.
// Defining FETCH_PERF_EN adds the perf_fetched/perf_redirects/perf_stall counter ports.
module fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_redirects,
    output logic [31:0]   perf_stall
`endif
);
    localparam int               PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CW      = PW + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [WIDTH-1:0] FOUR    = WIDTH'(4);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] req_pc_q, req_pc_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [WIDTH-1:0] tag_q [DEPTH];
    logic [WIDTH-1:0] tag_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             taken, push, pop, head_valid;
    logic [WIDTH-1:0] branch_off, branch_tgt, jump_tgt, target;

    // Jump wins over branch flags; the jump form keeps the top four PC bits.
    always_comb begin
        branch_off = {{(WIDTH-18){bus.br_imm26[15]}}, bus.br_imm26[15:0], 2'b00};
        branch_tgt = bus.br_pc + FOUR + branch_off;
        jump_tgt   = {bus.br_pc[WIDTH-1:28], bus.br_imm26, 2'b00};
        target     = bus.br_j ? jump_tgt : branch_tgt;
        taken      = bus.br_valid &
                     (bus.br_j | (bus.br_beq & bus.br_zf) | (bus.br_bne & ~bus.br_zf));
    end

    assign head_valid = (count_q != '0);

    always_comb begin
        push     = (state_q == S_WAIT) && bus.imem_valid && !taken;
        pop      = head_valid && bus.inst_ready && !taken;
        data_d   = data_q;
        tag_d    = tag_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (taken) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = bus.imem_rdata;
                tag_d[wr_ptr_q]  = req_pc_q;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Requests are only started with a free slot, so a returning response always fits.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        bus.imem_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_d < DEPTH_C) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                bus.imem_req = 1'b1;
                if (bus.imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + FOUR;
                    state_d  = taken ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_valid) begin
                    state_d = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
                end else if (taken) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.imem_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (taken) begin
            pc_d = target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = head_valid;
    assign bus.inst_data  = head_valid ? data_q[rd_ptr_q] : '0;
    assign bus.inst_pc    = head_valid ? tag_q[rd_ptr_q] : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_redirects_q, perf_redirects_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // A stall cycle is a full queue that decode does not drain.
    always_comb begin
        perf_fetched_d   = perf_fetched_q + {31'b0, push};
        perf_redirects_d = perf_redirects_q + {31'b0, taken};
        perf_stall_d     = perf_stall_q +
                           {31'b0, (count_q == DEPTH_C) && !(head_valid && bus.inst_ready)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q   <= '0;
            perf_redirects_q <= '0;
            perf_stall_q     <= '0;
        end else begin
            perf_fetched_q   <= perf_fetched_d;
            perf_redirects_q <= perf_redirects_d;
            perf_stall_q     <= perf_stall_d;
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_redirects = perf_redirects_q;
    assign perf_stall     = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: drives fetch_queue with a memory model returning addr>>2 and checks the
// decoded stream against a PC-sequence reference model plus table and hand-written cases.
`timescale 1ns/1ps
module tb_fetch_queue;
    localparam int          W        = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.WIDTH(W)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_redirects, perf_stall;
`endif

    fetch_queue #(.WIDTH(W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects),
        .perf_stall     (perf_stall)
`endif
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [25:0] imm26;
        logic        beq;
        logic        bne;
        logic        j;
        logic        zf;
        logic        exp_taken;
        logic [31:0] exp_target;
    } br_vec_t;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_due = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic        popped = 1'b0;
    logic [31:0] pop_pc = '0;
    int          pop_count = 0;
    logic        granted = 1'b0;
    logic [31:0] grant_log [$];
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    br_vec_t     drv_br = '0;
    logic        drv_ready = 1'b0;
    br_vec_t     vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] modelTarget(input br_vec_t b);
        int off;
        off = int'($signed(b.imm26[15:0])) * 4;
        if (b.j) return (b.pc & 32'hF000_0000) | ({6'b0, b.imm26} << 2);
        return b.pc + 32'd4 + 32'(off);
    endfunction

    function automatic br_vec_t mkVec(input logic v, input logic [31:0] pc, input logic [25:0] imm,
                                      input logic beq, input logic bne, input logic j, input logic zf,
                                      input logic tk, input logic [31:0] tgt);
        br_vec_t r;
        r = '{valid: v, pc: pc, imm26: imm, beq: beq, bne: bne, j: j, zf: zf,
              exp_taken: tk, exp_target: tgt};
        return r;
    endfunction

    // One clock step: memory model, branch/ready drive and reference-model pop checking.
    task automatic applyStimulus(input logic rst_in);
        logic        tk;
        logic [31:0] tgt;
        @(negedge clk);
        cyc++;
        popped  = 1'b0;
        granted = 1'b0;
        if (prev_hold) begin
            checkOutput("req_hold", 32'(bus.imem_req), 32'd1);
            checkOutput("addr_hold", bus.imem_addr, prev_addr);
        end
        if (pend) checkOutput("single_outstanding", 32'(bus.imem_req), 32'd0);
        rst = rst_in;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        if (pend && cyc >= pend_due) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = pend_addr >> 2;
            pend = 1'b0;
        end
        bus.imem_gnt = 1'b0;
        if (bus.imem_req && !pend && int'($urandom_range(99)) < gnt_pct) begin
            bus.imem_gnt = 1'b1;
            granted      = 1'b1;
            pend         = 1'b1;
            pend_addr    = bus.imem_addr;
            pend_due     = cyc + int'($urandom_range(lat_max, lat_min));
            grant_log.push_back(bus.imem_addr);
            checkOutput("addr_align", bus.imem_addr & 32'h3, 32'h0);
        end
        bus.br_valid   = drv_br.valid;
        bus.br_pc      = drv_br.pc;
        bus.br_imm26   = drv_br.imm26;
        bus.br_beq     = drv_br.beq;
        bus.br_bne     = drv_br.bne;
        bus.br_j       = drv_br.j;
        bus.br_zf      = drv_br.zf;
        bus.inst_ready = drv_ready;
        tk  = drv_br.valid & (drv_br.j | (drv_br.beq & drv_br.zf) | (drv_br.bne & ~drv_br.zf));
        tgt = modelTarget(drv_br);
        if (rst_in) begin
            exp_pc    = RESET_PC;
            prev_hold = 1'b0;
        end else begin
            if (bus.inst_valid && drv_ready && !tk) begin
                checkOutput("pop_pc", bus.inst_pc, exp_pc);
                checkOutput("pop_data", bus.inst_data, exp_pc >> 2);
                popped = 1'b1;
                pop_pc = bus.inst_pc;
                pop_count++;
                exp_pc = exp_pc + 32'd4;
            end
            if (tk) exp_pc = tgt;
            prev_hold = bus.imem_req && !bus.imem_gnt && !tk;
            prev_addr = bus.imem_addr;
        end
    endtask

    task automatic resetDut();
        int saved;
        saved     = gnt_pct;
        gnt_pct   = 0;
        drv_br    = '0;
        drv_ready = 1'b0;
        repeat (4) applyStimulus(1'b1);
        gnt_pct = saved;
    endtask

    task automatic waitPop(input string name, input int budget);
        int n;
        n = 0;
        applyStimulus(1'b0);
        while (!popped && n < budget) begin
            applyStimulus(1'b0);
            n++;
        end
        checkOutput(name, 32'(popped), 32'd1);
    endtask

    task automatic waitGrant(input string name, input int budget);
        int n;
        n = 0;
        applyStimulus(1'b0);
        while (!granted && n < budget) begin
            applyStimulus(1'b0);
            n++;
        end
        checkOutput(name, 32'(granted), 32'd1);
    endtask

    initial begin
        int          k;
        logic [31:0] prev;
        bus.imem_gnt = 1'b0; bus.imem_valid = 1'b0; bus.imem_rdata = '0;
        bus.br_valid = 1'b0; bus.br_pc = '0; bus.br_imm26 = '0;
        bus.br_beq = 1'b0; bus.br_bne = 1'b0; bus.br_j = 1'b0; bus.br_zf = 1'b0;
        bus.inst_ready = 1'b0;

        vecs[0] = mkVec(1, 32'h0000_0020, 26'h000FFFE, 1, 0, 0, 1, 1, 32'h0000_001C);
        vecs[1] = mkVec(1, 32'h3000_0010, 26'h0000040, 0, 0, 1, 0, 1, 32'h3000_0100);
        vecs[2] = mkVec(1, 32'h0000_0040, 26'h0000010, 0, 1, 0, 1, 0, 32'h0);
        vecs[3] = mkVec(1, 32'h0000_0100, 26'h0000010, 0, 1, 0, 0, 1, 32'h0000_0144);
        vecs[4] = mkVec(1, 32'h0000_0080, 26'h0000010, 1, 0, 0, 0, 0, 32'h0);
        vecs[5] = mkVec(1, 32'h0000_0044, 26'h3FFFFFF, 1, 0, 1, 0, 1, 32'h0FFF_FFFC);
        vecs[6] = mkVec(1, 32'h0001_0000, 26'h0008000, 1, 0, 0, 1, 1, 32'hFFFF_0004);
        vecs[7] = mkVec(0, 32'h0000_0500, 26'h0000010, 0, 0, 1, 0, 0, 32'h0);

        // Reset values and streaming with a 1-cycle memory.
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        resetDut();
        checkOutput("rst_req", 32'(bus.imem_req), 32'd0);
        checkOutput("rst_addr", bus.imem_addr, RESET_PC);
        checkOutput("rst_valid", 32'(bus.inst_valid), 32'd0);
        checkOutput("rst_data", bus.inst_data, 32'd0);
        checkOutput("rst_pc", bus.inst_pc, 32'd0);
        grant_log.delete();
        drv_ready = 1'b1;
        applyStimulus(1'b0);
        k = 0;
        while (!bus.inst_valid && k < 20) begin
            applyStimulus(1'b0);
            k++;
        end
        checkOutput("first_valid_latency", 32'(k), 32'd3);
        repeat (12) applyStimulus(1'b0);
        for (int i = 0; i < 4; i++)
            checkOutput("stream_addr", (grant_log.size() > i) ? grant_log[i] : 32'hDEAD_BEEF, 32'(i * 4));

        // Fill with decode stalled, then drain.
        resetDut();
        grant_log.delete();
        drv_ready = 1'b0;
        repeat (30) applyStimulus(1'b0);
        checkOutput("fill_grants", 32'(grant_log.size()), 32'd4);
        checkOutput("fill_req_low", 32'(bus.imem_req), 32'd0);
        checkOutput("fill_valid", 32'(bus.inst_valid), 32'd1);
        checkOutput("fill_head_pc", bus.inst_pc, 32'h0);
        drv_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitPop("fill_pop_seen", 20);
            checkOutput("fill_pop_pc", pop_pc, 32'(i * 4));
        end
        k = 0;
        while (grant_log.size() < 5 && k < 40) begin
            applyStimulus(1'b0);
            k++;
        end
        checkOutput("fill_resume_addr", (grant_log.size() >= 5) ? grant_log[4] : 32'hDEAD_BEEF, 32'h10);

        // Table of resolved branch records.
        resetDut();
        drv_ready = 1'b1;
        repeat (8) applyStimulus(1'b0);
        for (int v = 0; v < 8; v++) begin
            waitPop("tbl_pre_seen", 40);
            prev   = pop_pc;
            drv_br = vecs[v];
            applyStimulus(1'b0);
            drv_br = '0;
            if (popped) prev = pop_pc;
            waitPop("tbl_post_seen", 40);
            if (vecs[v].exp_taken) checkOutput("tbl_target", pop_pc, vecs[v].exp_target);
            else checkOutput("tbl_continue", pop_pc, prev + 32'd4);
        end

        // Redirect while the response is still outstanding.
        lat_min = 3; lat_max = 3;
        resetDut();
        drv_ready = 1'b1;
        waitGrant("wait_grant_seen", 20);
        drv_br = mkVec(1, 32'h0000_0200, 26'h0000010, 1, 0, 0, 1, 1, 32'h0000_0244);
        applyStimulus(1'b0);
        drv_br = '0;
        waitGrant("wait_redirect_grant", 20);
        checkOutput("wait_redirect_addr", grant_log[$], 32'h0000_0244);
        waitPop("wait_redirect_pop_seen", 20);
        checkOutput("wait_redirect_pop", pop_pc, 32'h0000_0244);

        // Reset in the middle of WAIT with the response landing during reset.
        resetDut();
        drv_ready = 1'b1;
        repeat (6) applyStimulus(1'b0);
        waitGrant("rstwait_grant_seen", 20);
        gnt_pct = 0;
        repeat (3) applyStimulus(1'b1);
        gnt_pct = 100;
        checkOutput("rstwait_empty", 32'(bus.inst_valid), 32'd0);
        checkOutput("rstwait_addr", bus.imem_addr, RESET_PC);
        waitPop("rstwait_pop_seen", 20);
        checkOutput("rstwait_restart", pop_pc, RESET_PC);

        // Randomised traffic against the PC-stream model.
        lat_min = 1; lat_max = 3; gnt_pct = 60;
        resetDut();
        k = pop_count;
        for (int i = 0; i < 3000; i++) begin
            drv_ready = ($urandom_range(9) < 7);
            drv_br    = '0;
            if ($urandom_range(99) < 4) begin
                drv_br.valid = 1'b1;
                drv_br.pc    = $urandom & 32'hFFFF_FFFC;
                drv_br.imm26 = 26'($urandom);
                drv_br.beq   = 1'($urandom_range(1));
                drv_br.bne   = 1'($urandom_range(1));
                drv_br.j     = 1'($urandom_range(1));
                drv_br.zf    = 1'($urandom_range(1));
            end
            applyStimulus(1'b0);
        end
        drv_br = '0;
        checkOutput("rand_progress", 32'((pop_count - k) > 200), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
